// File: rtl/mc_pkg.sv
// Shared definitions for the matrix calculator: element/matrix sizes,
// memory-stage control encodings and the loader state type.
package mc_pkg;

    localparam int MC_ELEM_W = 32;
    localparam int MC_ELEMS  = 16;
    localparam int MC_MAT_W  = MC_ELEM_W * MC_ELEMS;

    localparam logic MEM_LATCH = 1'b0;
    localparam logic MEM_LOAD  = 1'b1;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } loader_state_e;

endpackage

// File: rtl/matrix_loader.sv
// Assembles N elements (row-major) into one wide matrix word and presents it to
// the memory stage with a single-cycle load strobe once the matrix is complete.
module matrix_loader
    import mc_pkg::*;
#(
    parameter  int WIDTH = MC_ELEM_W,
    parameter  int N     = MC_ELEMS,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 abort,
    output logic [WIDTH*N-1:0]   Min,
    output logic                 memory_state,
    output logic                 loaded,
    output logic [CNT_W-1:0]     count
);

    loader_state_e        state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH*N-1:0]   min_q,   min_d;
    logic                 accept;

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, independent of statement order.
        if (!reset) begin
            state_q <= FILL;
            count_q <= '0;
            // NOTE: the matrix register is cleared on reset because its reset
            // value is architecturally visible on Min; plain storage would not be.
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            min_q   <= min_d;
        end
    end

    assign accept = in_valid && in_ready;

    // Next-state logic: abort takes priority over a same-cycle handshake.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        count_d = count_q;
        min_d   = min_q;
        case (state_q)
            FILL: begin
                if (abort) begin
                    count_d = '0;
                end else if (accept) begin
                    for (int i = 0; i < N; i++) begin
                        if (count_q == CNT_W'(i)) begin
                            min_d[WIDTH*i +: WIDTH] = in_data;
                        end
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(N - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = FILL;
                count_d = '0;
            end
            default: begin
                state_d = FILL;
                count_d = '0;
            end
        endcase
    end

    // Outputs decode registered state only; in_ready is also gated by reset.
    always_comb begin
        in_ready     = 1'b0;
        memory_state = MEM_LATCH;
        loaded       = 1'b0;
        case (state_q)
            FILL:    in_ready = reset;
            COMMIT: begin
                memory_state = MEM_LOAD;
                loaded       = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign Min   = min_q;
    assign count = count_q;

endmodule
